// File: rtl/tt_um_hoene_led_pwm_multi.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_led_pwm_multi
//
// Multi-channel LED PWM stage. One shared period counter drives CHANNELS PWM
// outputs of WIDTH-bit resolution (period = 2^WIDTH clocks). Duty values are
// double-buffered: a frame loaded from the protocol path sits in a shadow
// register and is copied into the active duty registers only at a period
// boundary, so a colour change never truncates or stretches a pulse. In
// staggered mode each channel counts with a fixed phase offset, which spreads
// the turn-on edges across the period and lowers the peak LED current.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   data           duty frame, channel i = data[i*WIDTH +: WIDTH]
//   load           single-cycle strobe, captures data into the shadow frame
//   enable         runs the period counter; low forces all outputs off
//   stagger        requests phase-staggered mode (applied at a boundary)
//   out            PWM outputs, active high, registered
//   period_start   one-cycle pulse aligned with count 0 on out
//   update_pending shadow holds a frame that has not been applied yet
//
// Parameters
//   CHANNELS       number of PWM outputs (>= 1)
//   WIDTH          duty and counter width in bits (>= 2)
// ---------------------------------------------------------------------------
module tt_um_hoene_led_pwm_multi #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic                      load,
    input  logic                      enable,
    input  logic                      stagger,
    output logic [CHANNELS-1:0]       out,
    output logic                      period_start,
    output logic                      update_pending
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Shared period counter and the flags that qualify it.
    logic [WIDTH-1:0] cnt;
    logic             boundary;

    // Double-buffered duty frame, kept flat so whole-frame transfers are a
    // single vector assignment.
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [CHANNELS*WIDTH-1:0] active;
    logic                      pending;
    logic                      stagger_act;

    // Combinational PWM decision for every channel, registered into out.
    logic [CHANNELS-1:0] out_next;

    // The last count of a running period. Everything that must be glitch-free
    // (frame transfer, stagger switch) happens only here.
    assign boundary = enable && (cnt == CNT_MAX);

    assign update_pending = pending;

    // -----------------------------------------------------------------------
    // Per-channel compare. The phase offset is an elaboration-time constant,
    // floor(i * 2^WIDTH / CHANNELS); the product is formed in 64 bits so it
    // cannot overflow for any practical WIDTH. The quotient is always below
    // 2^WIDTH, so keeping the low WIDTH bits loses nothing.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [63:0]      OFFSET_FULL = (64'(i) << WIDTH) / 64'(CHANNELS);
        localparam logic [WIDTH-1:0] OFFSET      = OFFSET_FULL[WIDTH-1:0];

        logic [WIDTH-1:0] phase;
        logic [WIDTH-1:0] local_cnt;
        logic [WIDTH-1:0] duty;

        assign phase     = stagger_act ? OFFSET : '0;
        // Modulo-2^WIDTH add: the carry is dropped so each channel's local
        // count wraps within the same period as the shared counter.
        assign local_cnt = cnt + phase;
        assign duty      = active[i*WIDTH +: WIDTH];
        // Strict less-than: duty 0 never lights, full-scale duty leaves
        // exactly one dark clock per period.
        assign out_next[i] = local_cnt < duty;
    end

    // -----------------------------------------------------------------------
    // Period counter. Dropping enable parks the counter at 0 so that
    // re-enabling always starts a fresh, full period.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Frame buffer. The shadow follows load at any time, even while disabled.
    // At a boundary the active frame takes the shadow as it was before this
    // edge, so a load coinciding with the boundary is kept for the next one
    // and pending stays set.
    // -----------------------------------------------------------------------
    // NOTE: the duty registers are reset, not left to power-up contents, so
    // a reset mid-frame is guaranteed to leave every LED dark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            stagger_act <= 1'b0;
        end else begin
            if (load) begin
                shadow <= data;
            end

            if (boundary) begin
                stagger_act <= stagger;
                if (pending) begin
                    active <= shadow;
                end
            end

            if (load) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs: the value shown in cycle n+1 reflects cnt, active
    // and stagger_act of cycle n, which keeps the pads free of compare
    // glitches.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else if (enable) begin
            out          <= out_next;
            period_start <= (cnt == '0);
        end else begin
            out          <= '0;
            period_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_tt_um_hoene_led_pwm_multi
//
// Directed bench for the multi-channel PWM stage at CHANNELS=3, WIDTH=4
// (period 16, stagger offsets 0/5/10). Each period is captured as one 16-bit
// pattern per output, bit k = output value at the sample marked as count k
// by period_start, and compared against hand-computed patterns.
// ---------------------------------------------------------------------------
module tb_tt_um_hoene_led_pwm_multi;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] data;
    logic                      load;
    logic                      enable;
    logic                      stagger;
    logic [CHANNELS-1:0]       out;
    logic                      period_start;
    logic                      update_pending;

    int checks   = 0;
    int failures = 0;

    tt_um_hoene_led_pwm_multi #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .load           (load),
        .enable         (enable),
        .stagger        (stagger),
        .out            (out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled and inputs driven 1 ns
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Records one full period starting at the current sample (count 0) and
    // compares each output's pattern plus the period_start pattern.
    task automatic capture_period(input string tag, input logic [15:0] e0,
                                  input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] p0, p1, p2, ps;
        for (int k = 0; k < 16; k++) begin
            if (k != 0) step();
            p0[k] = out[0];
            p1[k] = out[1];
            p2[k] = out[2];
            ps[k] = period_start;
        end
        check({tag, "_out0"}, 32'(p0), 32'(e0));
        check({tag, "_out1"}, 32'(p1), 32'(e1));
        check({tag, "_out2"}, 32'(p2), 32'(e2));
        check({tag, "_ps"},   32'(ps), 32'h0001);
    endtask

    // Steps until period_start is seen, bounded at 40 clocks.
    task automatic wait_period_start(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 40);
        check({tag, "_ps_seen"}, 32'(period_start), 32'd1);
    endtask

    function automatic logic [CHANNELS*WIDTH-1:0] frame(input logic [3:0] d0,
                                                        input logic [3:0] d1,
                                                        input logic [3:0] d2);
        return {d2, d1, d0};
    endfunction

    initial begin
        rst_n   = 1'b0;
        data    = '0;
        load    = 1'b0;
        enable  = 1'b0;
        stagger = 1'b0;
        step();
        step();
        check("rst_out", 32'(out), 32'd0);
        check("rst_ps",  32'(period_start), 32'd0);
        check("rst_pend", 32'(update_pending), 32'd0);

        // --- Basic duties {4,0,15}, unstaggered --------------------------
        rst_n  = 1'b1;
        enable = 1'b1;
        data   = frame(4'd4, 4'd0, 4'd15);
        load   = 1'b1;
        step();                                 // edge with cnt=0
        load   = 1'b0;
        check("first_ps",   32'(period_start), 32'd1);
        check("first_pend", 32'(update_pending), 32'd1);
        check("first_out",  32'(out), 32'd0);
        repeat (14) step();                     // edges cnt=1..14
        check("pend_before_bnd", 32'(update_pending), 32'd1);
        step();                                 // boundary edge cnt=15
        check("pend_after_bnd", 32'(update_pending), 32'd0);
        step();                                 // count 0 of new frame
        capture_period("basic", 16'h000F, 16'h0000, 16'h7FFF);

        // --- Duty 8 everywhere, staggered from the next period -------------
        data    = frame(4'd8, 4'd8, 4'd8);
        stagger = 1'b1;
        load    = 1'b1;
        step();                                 // count 0, old frame
        load    = 1'b0;
        capture_period("pre_stagger", 16'h000F, 16'h0000, 16'h7FFF);
        step();
        capture_period("stagger", 16'h00FF, 16'hF807, 16'h3FC0);
        check("stagger_pend", 32'(update_pending), 32'd0);

        // --- Two loads in one period: only the last one applies ------------
        stagger = 1'b0;
        repeat (5) step();                      // edges cnt=0..4
        data = frame(4'd3, 4'd3, 4'd3);
        load = 1'b1;
        step();                                 // load A at cnt=5
        load = 1'b0;
        check("loadA_pend", 32'(update_pending), 32'd1);
        repeat (4) step();                      // edges cnt=6..9
        data = frame(4'd9, 4'd9, 4'd9);
        load = 1'b1;
        step();                                 // load B at cnt=10
        load = 1'b0;
        wait_period_start("lastwins");
        capture_period("lastwins", 16'h01FF, 16'h01FF, 16'h01FF);

        // --- Load coinciding with the boundary ----------------------------
        repeat (2) step();                      // edges cnt=0..1
        data = frame(4'd5, 4'd6, 4'd7);
        load = 1'b1;
        step();                                 // load P at cnt=2
        load = 1'b0;
        repeat (12) step();                     // edges cnt=3..14
        data = frame(4'd12, 4'd12, 4'd12);
        load = 1'b1;
        step();                                 // load C at cnt=15
        load = 1'b0;
        check("bndload_pend0", 32'(update_pending), 32'd1);
        step();
        check("bndload_pend1", 32'(update_pending), 32'd1);
        capture_period("bndload_p", 16'h001F, 16'h003F, 16'h007F);
        check("bndload_pend2", 32'(update_pending), 32'd0);
        step();
        capture_period("bndload_c", 16'h0FFF, 16'h0FFF, 16'h0FFF);

        // --- Enable dropped for 7 cycles mid-period ----------------------
        repeat (5) step();                      // edges cnt=0..4
        enable = 1'b0;
        step();
        check("dis_out", 32'(out), 32'd0);
        check("dis_ps",  32'(period_start), 32'd0);
        data = frame(4'd2, 4'd2, 4'd2);
        load = 1'b1;
        step();
        load = 1'b0;
        check("dis_pend", 32'(update_pending), 32'd1);
        repeat (5) step();
        check("dis_out_late", 32'(out), 32'd0);
        enable = 1'b1;
        step();                                 // restart edge, cnt=0
        check("reen_pend", 32'(update_pending), 32'd1);
        capture_period("reen", 16'h0FFF, 16'h0FFF, 16'h0FFF);
        step();
        capture_period("reen_q", 16'h0003, 16'h0003, 16'h0003);

        // --- Reset mid-period with a pending frame ------------------------
        repeat (3) step();
        data = frame(4'd7, 4'd7, 4'd7);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (2) step();
        check("prerst_pend", 32'(update_pending), 32'd1);
        rst_n = 1'b0;
        step();
        check("midrst_out",  32'(out), 32'd0);
        check("midrst_ps",   32'(period_start), 32'd0);
        check("midrst_pend", 32'(update_pending), 32'd0);
        rst_n = 1'b1;
        step();                                 // cnt=0 after reset
        capture_period("postrst", 16'h0000, 16'h0000, 16'h0000);
        check("postrst_pend", 32'(update_pending), 32'd0);
        step();
        capture_period("postrst2", 16'h0000, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so a stalled run cannot hang the simulator.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
